// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  // Instruction class after opcode decode
  typedef enum logic [2:0] {
    K_NOP    = 3'd0,
    K_STORE  = 3'd1,
    K_ADD    = 3'd2,
    K_LOAD   = 3'd3,
    K_BRANCH = 3'd4,
    K_ALU    = 3'd5,
    K_HALT   = 3'd6
  } op_kind_t;

  localparam int unsigned OP_STORE   = 0;
  localparam int unsigned OP_ADD     = 1;
  localparam int unsigned OP_LOAD    = 2;
  localparam int unsigned OP_BRANCH  = 3;
  localparam int unsigned OP_HALT    = 15;  // all-ones at the default 4-bit width
  localparam int unsigned OP_ALU_GRP = 1;   // opcode[OPW-1:2] value of the 01xx group

  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_PASS = 7;

  localparam int unsigned TMR_W = 4;        // holds MEM_LAT up to 15

endpackage

// File: rtl/mem_wait_timer.sv
// Data-memory dwell timer: counts 0..MEM_LAT while enabled, flags the last MEM cycle.
module mem_wait_timer
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic last,
  output logic last_next
);

  logic [TMR_W-1:0] cnt;
  logic [TMR_W-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (load)
      cnt_n = '0;
    else if (en && !last)
      cnt_n = cnt + TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else
      cnt <= cnt_n;
  end

  assign last      = (cnt == TMR_W'(MEM_LAT));
  assign last_next = (cnt_n == TMR_W'(MEM_LAT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with halt/done handshake.
// Optional perf counters enabled by defining CTRL_PERF_CNT_EN.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned OPW     = 4,
  parameter int unsigned ALUW    = 3,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNTW    = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [OPW-1:0]  Opcode,
  output logic            PCEn,
  output logic            IREn,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic            ALUSrc,
  output logic            Branch,
  output logic [ALUW-1:0] ALUOp,
  output logic            Busy,
  output logic            Done,
  output logic [CNTW-1:0] CycleCnt,
  output logic [CNTW-1:0] InstrCnt
);

  function automatic op_kind_t classify(input logic [OPW-1:0] op);
    op_kind_t k;
    k = K_NOP;
    if (op == {OPW{1'b1}})
      k = K_HALT;
    else if (op[OPW-1:2] == (OPW-2)'(OP_ALU_GRP))
      k = K_ALU;
    else if (op == OPW'(OP_STORE))
      k = K_STORE;
    else if (op == OPW'(OP_ADD))
      k = K_ADD;
    else if (op == OPW'(OP_LOAD))
      k = K_LOAD;
    else if (op == OPW'(OP_BRANCH))
      k = K_BRANCH;
    return k;
  endfunction

  state_t         state;
  state_t         ns;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] op_n;
  op_kind_t       kind;
  logic           mem_last;
  logic           mem_last_n;
  logic           tmr_load;
  logic           tmr_en;

  logic            pcen_n, iren_n, regw_n, memw_n, m2r_n, alusrc_n, branch_n;
  logic [ALUW-1:0] aluop_n;

  // Opcode is only trusted in DECODE; later states use the captured copy
  assign op_n = (state == DECODE) ? Opcode : op_q;
  assign kind = classify(op_n);

  assign tmr_load = (ns == MEM) && (state != MEM);
  assign tmr_en   = (state == MEM);

  mem_wait_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_mem_wait_timer (
    .clk       (Clk),
    .rst_n     (Reset),
    .load      (tmr_load),
    .en        (tmr_en),
    .last      (mem_last),
    .last_next (mem_last_n)
  );

  always_comb begin
    ns = state;
    case (state)
      IDLE:   if (Start) ns = FETCH;
      FETCH:  ns = DECODE;
      DECODE: ns = (kind == K_HALT) ? HALT : EXEC;
      EXEC: begin
        case (kind)
          K_ADD, K_ALU:    ns = WB;
          K_LOAD, K_STORE: ns = MEM;
          default:         ns = FETCH;
        endcase
      end
      MEM:    if (mem_last) ns = (kind == K_LOAD) ? WB : FETCH;
      WB:     ns = FETCH;
      HALT:   if (Start) ns = FETCH;
      default: ns = IDLE;
    endcase
  end

  // Outputs for the upcoming state, registered so they align with it
  always_comb begin
    pcen_n   = 1'b0;
    iren_n   = 1'b0;
    regw_n   = 1'b0;
    memw_n   = 1'b0;
    m2r_n    = 1'b0;
    alusrc_n = 1'b0;
    branch_n = 1'b0;
    aluop_n  = ALUW'(ALU_PASS);
    case (ns)
      FETCH: iren_n = 1'b1;
      EXEC: begin
        case (kind)
          K_ADD: aluop_n = ALUW'(ALU_ADD);
          K_ALU: aluop_n = op_n[ALUW-1:0];
          K_LOAD, K_STORE: begin
            alusrc_n = 1'b1;
            aluop_n  = ALUW'(ALU_ADD);
          end
          K_BRANCH: begin
            branch_n = 1'b1;
            pcen_n   = 1'b1;
          end
          default: pcen_n = 1'b1;
        endcase
      end
      MEM: begin
        alusrc_n = 1'b1;
        aluop_n  = ALUW'(ALU_ADD);
        if ((kind == K_STORE) && mem_last_n) begin
          memw_n = 1'b1;
          pcen_n = 1'b1;
        end
      end
      WB: begin
        regw_n = 1'b1;
        m2r_n  = (kind == K_LOAD);
        pcen_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      op_q     <= '0;
      PCEn     <= 1'b0;
      IREn     <= 1'b0;
      RegWrite <= 1'b0;
      MemWrite <= 1'b0;
      MemtoReg <= 1'b0;
      ALUSrc   <= 1'b0;
      Branch   <= 1'b0;
      ALUOp    <= ALUW'(ALU_PASS);
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= ns;
      op_q     <= op_n;
      PCEn     <= pcen_n;
      IREn     <= iren_n;
      RegWrite <= regw_n;
      MemWrite <= memw_n;
      MemtoReg <= m2r_n;
      ALUSrc   <= alusrc_n;
      Branch   <= branch_n;
      ALUOp    <= aluop_n;
      Busy     <= (ns != IDLE) && (ns != HALT);
      Done     <= (ns == HALT);
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNTW-1:0] cyc_q;
  logic [CNTW-1:0] ins_q;

  // Saturating counters, cleared only by reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (Busy && (cyc_q != {CNTW{1'b1}}))
        cyc_q <= cyc_q + CNTW'(1);
      if (PCEn && (ins_q != {CNTW{1'b1}}))
        ins_q <= ins_q + CNTW'(1);
    end
  end

  assign CycleCnt = cyc_q;
  assign InstrCnt = ins_q;
`else
  assign CycleCnt = '0;
  assign InstrCnt = '0;
`endif

endmodule
